// File: rtl/countdown_timer_bcd_pkg.sv
// Shared clock definitions: FSM state encoding, BCD digit limits and the preset legality check.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned MIN_TENS_MAX = 5;
  localparam int unsigned ONES_MAX     = 9;

  function automatic logic preset_legal(input logic [3:0] mt, input logic [3:0] mo,
                                        input logic [3:0] st, input logic [3:0] so);
    return (mt <= 4'(MIN_TENS_MAX)) && (mo <= 4'(ONES_MAX)) &&
           (st <= 4'(SEC_TENS_MAX)) && (so <= 4'(ONES_MAX));
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// Control and display bundle of the countdown timer; clock and clear stay outside it.
interface countdown_timer_bcd_if;
  logic       tick_1hz;
  logic       load;
  logic [3:0] preset_min_tens;
  logic [3:0] preset_min_ones;
  logic [3:0] preset_sec_tens;
  logic [3:0] preset_sec_ones;
  logic       start;
  logic       pause;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;
  logic       alarm;
  logic       load_err;

  modport master (
    output tick_1hz, load, preset_min_tens, preset_min_ones, preset_sec_tens,
           preset_sec_ones, start, pause,
    input  min_tens, min_ones, sec_tens, sec_ones, running, done, alarm, load_err
  );

  modport slave (
    input  tick_1hz, load, preset_min_tens, preset_min_ones, preset_sec_tens,
           preset_sec_ones, start, pause,
    output min_tens, min_ones, sec_tens, sec_ones, running, done, alarm, load_err
  );
endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX and signals a borrow to the next digit.
module bcd_down_digit #(
  parameter int unsigned MAX = 9
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] preset,
  input  logic       dec_en,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = preset;
    end else if (dec_en) begin
      digit_d = (digit_q == 4'd0) ? 4'(MAX) : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign borrow_out = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer: preset load, 1 Hz decrement, done pulse at 00:00, timed alarm.
//   state | meaning
//   IDLE  | stopped, accepts load/start
//   RUN   | decrementing on each tick_1hz
//   PAUSE | count frozen, start resumes, legal load returns to IDLE
//   ALARM | expired, alarm high for ALARM_TICKS ticks
module countdown_timer_bcd
  import clock_pkg::*;
#(
  parameter int ALARM_TICKS = 10,
  parameter int TICK_W      = 8
) (
  input logic                 clock,
  input logic                 clear,
  countdown_timer_bcd_if.slave bus
);

  state_e            state_q, state_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              alarm_q, alarm_d;
  logic              load_err_q, load_err_d;
  logic [TICK_W-1:0] acnt_q, acnt_d;

  logic       load_dig, dec;
  logic [3:0] mt, mo, st, so;
  logic       b_so, b_st, b_mo, borrow_unused;
  logic       legal, at_zero, at_one;

  assign legal   = preset_legal(bus.preset_min_tens, bus.preset_min_ones,
                                bus.preset_sec_tens, bus.preset_sec_ones);
  assign at_zero = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
  assign at_one  = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd1);

  always_comb begin
    state_d    = state_q;
    acnt_d     = acnt_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    load_dig   = 1'b0;
    dec        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          load_dig   = legal;
          load_err_d = !legal;
        end else if (bus.start && !bus.pause && !at_zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.pause) begin
          state_d = PAUSE;
        end else if (bus.tick_1hz) begin
          dec = 1'b1;
          if (at_one) begin
            state_d = ALARM;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.load) begin
          load_dig   = legal;
          load_err_d = !legal;
          if (legal) state_d = IDLE;
        end else if (bus.start && !bus.pause) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        if (bus.load) begin
          load_dig   = legal;
          load_err_d = !legal;
          state_d    = IDLE;
        end else if (bus.start && !bus.pause) begin
          state_d = IDLE;
        end else if (bus.tick_1hz) begin
          if (acnt_q == TICK_W'(ALARM_TICKS - 1)) state_d = IDLE;
          else                                    acnt_d  = acnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // the alarm counter only means something while the alarm is sounding
    if (state_d != ALARM) acnt_d = '0;
    running_d = (state_d == RUN);
    alarm_d   = (state_d == ALARM);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
      acnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      done_q     <= done_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
      acnt_q     <= acnt_d;
    end
  end

  bcd_down_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clock(clock), .clear(clear), .load(load_dig), .preset(bus.preset_sec_ones),
    .dec_en(dec), .digit(so), .borrow_out(b_so)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock(clock), .clear(clear), .load(load_dig), .preset(bus.preset_sec_tens),
    .dec_en(b_so), .digit(st), .borrow_out(b_st)
  );

  bcd_down_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clock(clock), .clear(clear), .load(load_dig), .preset(bus.preset_min_ones),
    .dec_en(b_st), .digit(mo), .borrow_out(b_mo)
  );

  // 00:00 is never decremented, so the top borrow can never fire
  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clock(clock), .clear(clear), .load(load_dig), .preset(bus.preset_min_tens),
    .dec_en(b_mo), .digit(mt), .borrow_out(borrow_unused)
  );

  assign bus.min_tens = mt;
  assign bus.min_ones = mo;
  assign bus.sec_tens = st;
  assign bus.sec_ones = so;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: directed scenarios plus random traffic against a seconds-based model.
module tb_countdown_timer_bcd;

  localparam int ALARM_TICKS = 4;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  countdown_timer_bcd_if bus ();

  countdown_timer_bcd #(.ALARM_TICKS(ALARM_TICKS), .TICK_W(8)) dut (
    .clock(clock), .clear(clear), .bus(bus)
  );

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mode_e;

  mode_e m_mode = M_IDLE;
  int    m_secs = 0;
  int    m_alarm_left = 0;
  bit    m_done = 1'b0;
  bit    m_lerr = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [15:0] secs_to_bcd(input int s);
    logic [15:0] r;
    r[15:12] = 4'((s / 60) / 10);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  task automatic model_step(input bit tk, ld, sr, ps, cl, input logic [15:0] pre);
    bit legal;
    int psecs;
    legal = (pre[15:12] <= 5) && (pre[11:8] <= 9) && (pre[7:4] <= 5) && (pre[3:0] <= 9);
    psecs = (int'(pre[15:12]) * 10 + int'(pre[11:8])) * 60 + int'(pre[7:4]) * 10 + int'(pre[3:0]);
    m_done = 1'b0;
    m_lerr = 1'b0;
    if (cl) begin
      m_mode = M_IDLE;
      m_secs = 0;
      m_alarm_left = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (ld) begin
          if (legal) m_secs = psecs;
          else       m_lerr = 1'b1;
        end else if (sr && !ps && m_secs != 0) m_mode = M_RUN;
      end
      M_RUN: begin
        if (ps) m_mode = M_PAUSE;
        else if (tk) begin
          m_secs--;
          if (m_secs == 0) begin
            m_mode = M_ALARM;
            m_done = 1'b1;
            m_alarm_left = ALARM_TICKS;
          end
        end
      end
      M_PAUSE: begin
        if (ld) begin
          if (legal) begin
            m_secs = psecs;
            m_mode = M_IDLE;
          end else m_lerr = 1'b1;
        end else if (sr && !ps) m_mode = M_RUN;
      end
      default: begin
        if (ld) begin
          if (legal) m_secs = psecs;
          else       m_lerr = 1'b1;
          m_mode = M_IDLE;
        end else if (sr && !ps) m_mode = M_IDLE;
        else if (tk) begin
          m_alarm_left--;
          if (m_alarm_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic cyc(input bit tk, ld, sr, ps, cl, input logic [15:0] pre);
    bus.tick_1hz        = tk;
    bus.load            = ld;
    bus.start           = sr;
    bus.pause           = ps;
    clear               = cl;
    bus.preset_min_tens = pre[15:12];
    bus.preset_min_ones = pre[11:8];
    bus.preset_sec_tens = pre[7:4];
    bus.preset_sec_ones = pre[3:0];
    @(posedge clock);
    model_step(tk, ld, sr, ps, cl, pre);
    #1;
    chk("digits",   dut_digits(), secs_to_bcd(m_secs));
    chk("running",  16'(bus.running),  16'(m_mode == M_RUN));
    chk("done",     16'(bus.done),     16'(m_done));
    chk("alarm",    16'(bus.alarm),    16'(m_mode == M_ALARM));
    chk("load_err", 16'(bus.load_err), 16'(m_lerr));
    bus.tick_1hz = 1'b0;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    clear        = 1'b0;
  endtask

  logic [15:0] exp_seq [6];
  logic [15:0] pre_r;

  initial begin
    bus.tick_1hz = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.preset_min_tens = 4'd0; bus.preset_min_ones = 4'd0;
    bus.preset_sec_tens = 4'd0; bus.preset_sec_ones = 4'd0;
    exp_seq = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100, 16'h0059};

    // reset
    cyc(0, 0, 0, 0, 1, 16'h0000);
    chk("reset_digits", dut_digits(), 16'h0000);
    chk("reset_flags", {12'd0, bus.running, bus.done, bus.alarm, bus.load_err}, 16'h0000);

    // 01:05 counting through a minute borrow
    cyc(0, 1, 0, 0, 0, 16'h0105);
    chk("load_0105", dut_digits(), 16'h0105);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0, 0, 16'h0000);
      chk("run_seq", dut_digits(), exp_seq[i]);
      chk("run_running", 16'(bus.running), 16'h0001);
      cyc(0, 0, 0, 0, 0, 16'h0000);
    end

    // expiry and timed alarm
    cyc(0, 0, 0, 1, 0, 16'h0000);
    cyc(0, 1, 0, 0, 0, 16'h0002);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 0, 0, 16'h0000);
    chk("exp_0001", dut_digits(), 16'h0001);
    cyc(1, 0, 0, 0, 0, 16'h0000);
    chk("exp_done", {bus.done, bus.alarm, 14'd0}, 16'hC000);
    cyc(0, 0, 0, 0, 0, 16'h0000);
    chk("done_once", 16'(bus.done), 16'h0000);
    for (int i = 0; i < ALARM_TICKS; i++) begin
      chk("alarm_held", 16'(bus.alarm), 16'h0001);
      cyc(1, 0, 0, 0, 0, 16'h0000);
      cyc(0, 0, 0, 0, 0, 16'h0000);
    end
    chk("alarm_end", 16'(bus.alarm), 16'h0000);

    // zero start ignored, illegal preset rejected
    cyc(0, 1, 0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    chk("zero_start", 16'(bus.running), 16'h0000);
    cyc(0, 1, 0, 0, 0, 16'h6000);
    chk("illegal_load", {bus.load_err, 15'd0}, 16'h8000);
    chk("illegal_keep", dut_digits(), 16'h0000);

    // pause beats tick, ticks ignored while paused
    cyc(0, 1, 0, 0, 0, 16'h1000);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 1, 0, 16'h0000);
    chk("pause_tick", dut_digits(), 16'h1000);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 16'h0000);
    chk("paused_hold", dut_digits(), 16'h1000);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 0, 0, 16'h0000);
    chk("resume_0959", dut_digits(), 16'h0959);

    // clear mid-run, then abort an alarm with start
    cyc(0, 0, 0, 1, 0, 16'h0000);
    cyc(0, 1, 0, 0, 0, 16'h0030);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 0, 1, 16'h0000);
    chk("clear_run", {dut_digits()}, 16'h0000);
    chk("clear_flags", {12'd0, bus.running, bus.done, bus.alarm, bus.load_err}, 16'h0000);
    cyc(0, 1, 0, 0, 0, 16'h0001);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    cyc(1, 0, 0, 0, 0, 16'h0000);
    chk("abort_pre", 16'(bus.alarm), 16'h0001);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    chk("abort_alarm", 16'(bus.alarm), 16'h0000);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 7) == 0) pre_r = 16'($urandom);
      else pre_r = {4'd0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0, pre_r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
